// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control unit: sequences FETCH/DECODE/EXEC/MEM/WB over one shared
// ready-handshaked memory port, with a memory-wait timeout, sticky fault code and retire counter.
module multicycle_control #(
    parameter int OPCODE_W       = 11,
    parameter int ALUOP_W        = 4,
    parameter int SIGNOP_W       = 3,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                alu_zero,
    output logic                imem_read,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg2loc,
    output logic                alusrc,
    output logic                mem2reg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [SIGNOP_W-1:0] signop,
    output logic [2:0]          state,
    output logic [1:0]          fault,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI,
        C_MOVZ, C_B, C_CBZ, C_LDUR, C_STUR, C_ILL
    } cls_t;

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT =
        WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    function automatic cls_t classify(input logic [OPCODE_W-1:0] op);
        cls_t c;
        casez (op)
            11'b?0001010???: c = C_AND;
            11'b?0101010???: c = C_ORR;
            11'b?0?01011???: c = C_ADD;
            11'b?1?01011???: c = C_SUB;
            11'b?0?10001???: c = C_ADDI;
            11'b?1?10001???: c = C_SUBI;
            11'b110100101??: c = C_MOVZ;
            11'b?00101?????: c = C_B;
            11'b?011010????: c = C_CBZ;
            11'b??111000010: c = C_LDUR;
            11'b??111000000: c = C_STUR;
            default:         c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [ALUOP_W-1:0] aluop_of(input cls_t c);
        logic [3:0] a;
        case (c)
            C_ORR:                         a = 4'b0001;
            C_ADD, C_ADDI, C_LDUR, C_STUR: a = 4'b0010;
            C_SUB, C_SUBI:                 a = 4'b0110;
            C_MOVZ, C_CBZ:                 a = 4'b0111;
            default:                       a = 4'b0000;
        endcase
        return ALUOP_W'(a);
    endfunction

    function automatic logic [SIGNOP_W-1:0] signop_of(input cls_t c);
        logic [2:0] s;
        case (c)
            C_LDUR, C_STUR: s = 3'b001;
            C_B:            s = 3'b010;
            C_CBZ:          s = 3'b011;
            C_MOVZ:         s = 3'b100;
            default:        s = 3'b000;
        endcase
        return SIGNOP_W'(s);
    endfunction

    function automatic logic uses_imm(input cls_t c);
        return (c == C_ADDI) || (c == C_SUBI) || (c == C_MOVZ) || (c == C_LDUR) || (c == C_STUR);
    endfunction

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   op_q, op_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [1:0]            fault_q, fault_d;
    logic [CNT_W-1:0]      retired_q, retired_d;
    cls_t                  dec_cls, op_cls;
    logic                  timeout_hit;

    assign dec_cls     = classify(opcode);
    assign op_cls      = classify(op_q);
    // The limit is reached on a low cycle only; a ready in that cycle completes normally.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_q == WAIT_LIMIT);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = wait_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    wait_d = '0;
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else if (op_cls == C_STUR) begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + CNT_W'(1);
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    wait_d  = '0;
                    state_d = S_HALT;
                    if (fault_q == 2'b00) fault_d = 2'b10;
                end else if (TIMEOUT_CYCLES > 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (dec_cls == C_ILL) begin
                    state_d = S_HALT;
                    if (fault_q == 2'b00) fault_d = 2'b01;
                end else if (dec_cls == C_B) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + CNT_W'(1);
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_cls == C_CBZ) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + CNT_W'(1);
                end else if ((op_cls == C_LDUR) || (op_cls == C_STUR)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            fault_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        imem_read = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg2loc   = 1'b0;
        alusrc    = 1'b0;
        mem2reg   = 1'b0;
        regwrite  = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        aluop     = '0;
        signop    = '0;
        case (state_q)
            S_FETCH: begin
                imem_read = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                reg2loc = (dec_cls == C_CBZ) || (dec_cls == C_STUR);
                if (dec_cls == C_B) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                    signop   = signop_of(C_B);
                end
            end
            S_EXEC: begin
                aluop  = aluop_of(op_cls);
                alusrc = uses_imm(op_cls);
                signop = signop_of(op_cls);
                if (op_cls == C_CBZ) begin
                    pc_write = alu_zero;
                    pc_src   = 1'b1;
                end
            end
            S_MEM: begin
                memread  = (op_cls == C_LDUR);
                memwrite = (op_cls == C_STUR);
                aluop    = ALUOP_W'(4'b0010);
                alusrc   = 1'b1;
            end
            S_WB: begin
                regwrite = 1'b1;
                mem2reg  = (op_cls == C_LDUR);
            end
            default: ;
        endcase
        // Reset forces every strobe low even though the state register already reads FETCH.
        if (Reset) begin
            imem_read = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 1'b0;
            reg2loc   = 1'b0;
            alusrc    = 1'b0;
            mem2reg   = 1'b0;
            regwrite  = 1'b0;
            memread   = 1'b0;
            memwrite  = 1'b0;
            aluop     = '0;
            signop    = '0;
        end
    end

    assign state   = state_q;
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference schedule feeds a scoreboard queue;
// a negedge monitor pops and compares the main DUT and a no-timeout, 3-bit-counter twin.
module tb_multicycle_control;

    localparam int TMO = 15;
    localparam int C_CBZ = 8, C_B = 7, C_LDUR = 9, C_STUR = 10, C_ILL = 11;
    localparam int ALU_T [0:10] = '{0, 1, 2, 6, 2, 6, 7, 0, 7, 2, 2};
    localparam int SGN_T [0:10] = '{0, 0, 0, 0, 0, 0, 4, 2, 3, 1, 1};
    localparam int IMM_T [0:10] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    localparam logic [3:0] PH_RST = 0, PH_FW = 1, PH_FR = 2, PH_DEC = 3, PH_EXE = 4,
                           PH_MEMW = 5, PH_MEMR = 6, PH_WB = 7, PH_HALT = 8;

    string pats [0:10] = '{"?0001010???", "?0101010???", "?0?01011???", "?1?01011???",
                           "?0?10001???", "?1?10001???", "110100101??", "?00101?????",
                           "?011010????", "??111000010", "??111000000"};

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  flt;
        logic [31:0] ret;
        logic imem, irw, pcw, pcs, r2l, asrc, m2r, rw, mrd, mwr;
        logic [3:0]  aop;
        logic [2:0]  sop;
    } obs_t;

    typedef struct packed {
        obs_t       m;
        obs_t       a;
        logic [3:0] ph;
    } exp_t;

    logic CLK = 1'b0, Reset = 1'b1, mem_ready = 1'b0, alu_zero = 1'b0;
    logic [10:0] opcode = '0;

    logic imem_read, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite;
    logic [3:0] aluop;
    logic [2:0] signop, state;
    logic [1:0] fault;
    logic [31:0] retired;

    logic a_imem_read, a_ir_write, a_pc_write, a_pc_src, a_reg2loc, a_alusrc, a_mem2reg;
    logic a_regwrite, a_memread, a_memwrite;
    logic [3:0] a_aluop;
    logic [2:0] a_signop, a_state;
    logic [1:0] a_fault;
    logic [2:0] a_retired;

    always #5 CLK = ~CLK;

    multicycle_control #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .imem_read(imem_read), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite), .aluop(aluop), .signop(signop),
        .state(state), .fault(fault), .retired(retired)
    );

    multicycle_control #(.TIMEOUT_CYCLES(0), .CNT_W(3)) dut_alt (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .imem_read(a_imem_read), .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_src(a_pc_src),
        .reg2loc(a_reg2loc), .alusrc(a_alusrc), .mem2reg(a_mem2reg), .regwrite(a_regwrite),
        .memread(a_memread), .memwrite(a_memwrite), .aluop(a_aluop), .signop(a_signop),
        .state(a_state), .fault(a_fault), .retired(a_retired)
    );

    exp_t        exp_q [$];
    int          n_pass = 0, n_total = 0;
    int unsigned m_ret = 0;
    logic [1:0]  m_flt = 2'b00;
    bit          frozen = 1'b0;
    obs_t        frozen_obs;

    function automatic int classify(input logic [10:0] op);
        bit  ok;
        byte ch;
        for (int c = 0; c < 11; c++) begin
            ok = 1'b1;
            for (int i = 0; i < 11; i++) begin
                ch = pats[c].getc(i);
                if ((ch == "0" && op[10-i]) || (ch == "1" && !op[10-i])) ok = 1'b0;
            end
            if (ok) return c;
        end
        return C_ILL;
    endfunction

    function automatic logic [10:0] gen_from(input int c);
        logic [10:0] op;
        byte ch;
        for (int i = 0; i < 11; i++) begin
            ch = pats[c].getc(i);
            op[10-i] = (ch == "?") ? 1'($urandom) : (ch == "1");
        end
        return op;
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [10:0] rop();
        return 11'($urandom);
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o     = '0;
        o.st  = st;
        o.flt = m_flt;
        o.ret = m_ret;
        return o;
    endfunction

    function automatic string phname(input logic [3:0] ph);
        case (ph)
            PH_RST:  return "reset";
            PH_FW:   return "fetch_wait";
            PH_FR:   return "fetch_ready";
            PH_DEC:  return "decode";
            PH_EXE:  return "exec";
            PH_MEMW: return "mem_wait";
            PH_MEMR: return "mem_ready";
            PH_WB:   return "writeback";
            default: return "halt";
        endcase
    endfunction

    task automatic step(input obs_t o, input logic [3:0] ph, input logic mr_i,
                        input logic az_i, input logic [10:0] op_i);
        exp_t e;
        mem_ready = mr_i;
        alu_zero  = az_i;
        opcode    = op_i;
        e.m       = o;
        e.a       = frozen ? frozen_obs : o;
        e.a.ret   = e.a.ret & 32'h7;
        e.ph      = ph;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_phase(input bit is_mem, input int lows, input int c,
                              input logic [10:0] op, output bit ok);
        obs_t o;
        int   n;
        n = (lows >= TMO) ? TMO : lows;
        o = base(is_mem ? 3'd3 : 3'd0);
        if (is_mem) begin
            o.mrd  = (c == C_LDUR);
            o.mwr  = (c == C_STUR);
            o.aop  = 4'd2;
            o.asrc = 1'b1;
        end else begin
            o.imem = 1'b1;
        end
        for (int k = 0; k < n; k++) step(o, is_mem ? PH_MEMW : PH_FW, 1'b0, rbit(), is_mem ? op : rop());
        if (lows >= TMO) begin
            frozen     = 1'b1;
            frozen_obs = o;
            if (m_flt == 2'b00) m_flt = 2'b10;
            ok = 1'b0;
            return;
        end
        if (!is_mem) begin
            o.irw = 1'b1;
            o.pcw = 1'b1;
        end
        step(o, is_mem ? PH_MEMR : PH_FR, 1'b1, rbit(), is_mem ? op : rop());
        ok = 1'b1;
    endtask

    task automatic run_instr(input logic [10:0] op, input int fst, input int mst, input logic z);
        int   c;
        bit   ok;
        obs_t o;
        c = classify(op);
        wait_phase(1'b0, fst, c, op, ok);
        if (!ok) return;
        o     = base(3'd1);
        o.r2l = (c == C_CBZ) || (c == C_STUR);
        if (c == C_B) begin
            o.pcw = 1'b1;
            o.pcs = 1'b1;
            o.sop = 3'd2;
        end
        step(o, PH_DEC, rbit(), rbit(), op);
        if (c == C_ILL) begin
            if (m_flt == 2'b00) m_flt = 2'b01;
            return;
        end
        if (c == C_B) begin
            m_ret++;
            return;
        end
        o      = base(3'd2);
        o.aop  = 4'(ALU_T[c]);
        o.sop  = 3'(SGN_T[c]);
        o.asrc = (IMM_T[c] != 0);
        if (c == C_CBZ) begin
            o.pcw = z;
            o.pcs = 1'b1;
        end
        step(o, PH_EXE, rbit(), z, op);
        if (c == C_CBZ) begin
            m_ret++;
            return;
        end
        if (c == C_LDUR || c == C_STUR) begin
            wait_phase(1'b1, mst, c, op, ok);
            if (!ok) return;
            if (c == C_STUR) begin
                m_ret++;
                return;
            end
        end
        o     = base(3'd4);
        o.rw  = 1'b1;
        o.m2r = (c == C_LDUR);
        step(o, PH_WB, rbit(), rbit(), op);
        m_ret++;
    endtask

    task automatic halt_cycles(input int n);
        for (int k = 0; k < n; k++) step(base(3'd5), PH_HALT, frozen ? 1'b0 : rbit(), rbit(), rop());
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        m_ret  = 0;
        m_flt  = 2'b00;
        frozen = 1'b0;
        for (int k = 0; k < 2; k++) step(base(3'd0), PH_RST, 1'b1, rbit(), rop());
        Reset = 1'b0;
    endtask

    task automatic ldur_aborted_by_reset();
        obs_t o;
        o = base(3'd0);
        o.imem = 1'b1;
        o.irw  = 1'b1;
        o.pcw  = 1'b1;
        step(o, PH_FR, 1'b1, rbit(), rop());
        step(base(3'd1), PH_DEC, rbit(), rbit(), 11'h7C2);
        o = base(3'd2);
        o.aop  = 4'd2;
        o.asrc = 1'b1;
        o.sop  = 3'd1;
        step(o, PH_EXE, rbit(), rbit(), 11'h7C2);
        o = base(3'd3);
        o.mrd  = 1'b1;
        o.aop  = 4'd2;
        o.asrc = 1'b1;
        for (int k = 0; k < 2; k++) step(o, PH_MEMW, 1'b0, rbit(), 11'h7C2);
        do_reset();
    endtask

    initial begin
        exp_t e;
        obs_t am, aa;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                am = {state, fault, retired, imem_read, ir_write, pc_write, pc_src, reg2loc,
                      alusrc, mem2reg, regwrite, memread, memwrite, aluop, signop};
                aa = {a_state, a_fault, {29'd0, a_retired}, a_imem_read, a_ir_write, a_pc_write,
                      a_pc_src, a_reg2loc, a_alusrc, a_mem2reg, a_regwrite, a_memread, a_memwrite,
                      a_aluop, a_signop};
                n_total++;
                if (am === e.m) n_pass++;
                else $display("FAIL cyc %0d %s main: got %h (state %0d retired %0d) want %h (state %0d retired %0d)",
                              cyc, phname(e.ph), am, am.st, am.ret, e.m, e.m.st, e.m.ret);
                n_total++;
                if (aa === e.a) n_pass++;
                else $display("FAIL cyc %0d %s twin: got %h (state %0d) want %h (state %0d)",
                              cyc, phname(e.ph), aa, aa.st, e.a, e.a.st);
            end
        end
    end

    initial begin
        @(posedge CLK);
        #1;
        do_reset();
        run_instr(11'h458, 0, 0, 1'b0);
        run_instr(11'h7C2, 0, 3, 1'b0);
        run_instr(11'h5A0, 0, 0, 1'b1);
        run_instr(11'h5A0, 1, 0, 1'b0);
        run_instr(11'h0A0, 0, 0, 1'b0);
        run_instr(11'h7C0, 2, 1, 1'b0);
        run_instr(11'h694, 0, 0, 1'b0);
        run_instr(11'h458, TMO - 1, 0, 1'b0);
        run_instr(11'h7C2, 0, TMO - 1, 1'b0);
        ldur_aborted_by_reset();
        run_instr(11'h458, 0, 0, 1'b0);

        run_instr(11'h000, 0, 0, 1'b0);
        halt_cycles(20);
        do_reset();

        run_instr(11'h458, 40, 0, 1'b0);
        halt_cycles(25);
        do_reset();

        run_instr(11'h7C2, 0, 20, 1'b0);
        halt_cycles(5);
        do_reset();

        for (int i = 0; i < 80; i++) begin
            logic [10:0] op;
            int          sel;
            sel = $urandom_range(0, 11);
            op  = (sel == 11) ? rop() : gen_from(sel);
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 4), rbit());
            if (m_flt != 2'b00) begin
                halt_cycles(3);
                do_reset();
            end
        end

        repeat (3) @(negedge CLK);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle LEGv8 control unit. Replaces the combinational single-cycle decoder with an FSM that sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Shares one memory port, whose accesses complete on a ready handshake.
- Adds a memory-wait timeout, sticky fault reporting and a retired-instruction counter.
- Sits between the IR/datapath and the register file, ALU, memory and PC logic.

Parameters:
- OPCODE_W, 11, instruction opcode field width (bits [31:21]).
- ALUOP_W, 4, ALU operation code width.
- SIGNOP_W, 3, sign-extender mode width.
- TIMEOUT_CYCLES, 15, maximum cycles waiting for mem_ready before fault; 0 disables the timeout.
- CNT_W, 32, retired-instruction counter width.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- opcode  in  OPCODE_W  IR[31:21], valid from DECODE onward.
- mem_ready  in  1  memory access complete this cycle.
- alu_zero  in  1  ALU zero flag, used for CBZ.
- imem_read  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg2loc  out  1  read-register-2 select.
- alusrc  out  1  ALU B = immediate.
- mem2reg  out  1  writeback from memory.
- regwrite  out  1  register write strobe.
- memread  out  1  data memory read.
- memwrite  out  1  data memory write.
- aluop  out  ALUOP_W  ALU control.
- signop  out  SIGNOP_W  sign-extend mode.
- state  out  3  current FSM state.
- fault  out  2  sticky; 00 none, 01 illegal opcode, 10 memory timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (asynchronous): state=FETCH, op_q=0, wait counter=0, fault=00, retired=0. While Reset is high, every strobe output is 0.
- Outputs are combinational from state and op_q. Every don't-care output is driven 0; no X is ever driven.
- Opcode classes: ANDREG ?0001010???, ORRREG ?0101010???, ADDREG ?0?01011???, SUBREG ?1?01011???, ADDIMM ?0?10001???, SUBIMM ?1?10001???, MOVZ 110100101??, B ?00101?????, CBZ ?011010????, LDUR ??111000010, STUR ??111000000. Priority is the order listed.
- aluop: AND 0000, ORR 0001, ADD/ADDIMM/LDUR/STUR 0010, SUB/SUBIMM 0110, MOVZ/CBZ 0111.
- signop: imm 000, LDUR/STUR 001, B 010, CBZ 011, MOVZ 100.
- FETCH (000): imem_read=1 each cycle until mem_ready. On the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE (001): op_q <= opcode.
  - Illegal opcode: fault=01, go to HALT.
  - B: pc_write=1, pc_src=1, signop=010, retired++, go to FETCH.
  - All others: go to EXEC.
  - reg2loc=1 for CBZ/STUR.
- EXEC (010): aluop, alusrc and signop driven from op_q. alusrc=1 for imm/MOVZ/LDUR/STUR.
  - CBZ: pc_write=alu_zero, pc_src=1, retired++, go to FETCH.
  - LDUR/STUR: go to MEM.
  - All others: go to WB.
- MEM (011): memread (LDUR) or memwrite (STUR) held high until mem_ready; aluop=0010 and alusrc=1 held.
  - On mem_ready: STUR does retired++ and goes to FETCH; LDUR goes to WB.
- WB (100): regwrite=1; mem2reg=1 for LDUR, else 0. retired++, go to FETCH.
- HALT (101): all strobes 0. Left only via Reset.
- Memory timeout: the wait counter counts cycles in FETCH/MEM with mem_ready low and clears on state change.
  - If TIMEOUT_CYCLES>0 and the count reaches TIMEOUT_CYCLES: fault=10, go to HALT.
  - mem_ready high in the same cycle the limit is reached wins (normal completion).
- fault is sticky; the first fault recorded wins.
- retired wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts it immediately; no strobe pulses on release.

Test Plan:
- Reset high, then low with mem_ready=1 and opcode=0x458 (ADD): states 0,1,2,4. ir_write/pc_write in cycle 1, regwrite in cycle 4, aluop=0010, retired=1.
- opcode=0x7C2 (LDUR), mem_ready low 3 cycles in MEM: memread held 4 cycles, then WB with mem2reg=1 and regwrite=1, retired increments once.
- opcode=0x5A0 (CBZ): alu_zero=1 gives pc_write=1, pc_src=1 in EXEC; alu_zero=0 gives pc_write=0. Both go to FETCH, retired +1.
- opcode=0x0A0 (B): 2-cycle instruction, pc_src=1 in DECODE, signop=010. regwrite, memread and memwrite stay 0 throughout.
- opcode=0x000: fault=01, state=5. All strobes stay 0 for 20 cycles; Reset clears.
- mem_ready stuck low in FETCH: after 15 cycles fault=10 and HALT. With TIMEOUT_CYCLES=0, stays in FETCH indefinitely.
